rptr_empty: RTL and testbench
=============================

Name: rptr_empty

Overview:
- Read-domain pointer and empty-flag generator for the dual-clock FIFO.
- Consumes the write pointer synchronised into rclk (rq2_wptr, Gray) and advances the read pointer on accepted reads.
- Produces:
  - the binary RAM read address
  - the Gray read pointer (rptr), handed to the read-to-write synchroniser
  - a registered empty flag
  - fill level
  - sticky underflow status

Parameters:
- Addr_Width, 4, RAM address width; FIFO depth = 2**Addr_Width; pointers are Addr_Width+1 bits (extra wrap bit).
- AE_Thresh, 2, almost-empty threshold in entries; used only when ASYNC_FIFO_ALMOST_EMPTY_EN is defined.

Ports:
- rclk  input  1  read-domain clock
- rrst_n  input  1  asynchronous active-low reset, read domain
- rinc  input  1  read request; accepted only when rempty=0
- rq2_wptr  input  Addr_Width+1  Gray write pointer, already two-flop synchronised to rclk
- rclr_uf  input  1  clears runderflow
- raddr  output  Addr_Width  binary RAM read address
- rptr  output  Addr_Width+1  Gray read pointer, registered
- rempty  output  1  FIFO empty, registered
- rlevel  output  Addr_Width+1  entries available, registered, conservative
- runderflow  output  1  sticky: rinc seen while rempty=1
- ralmost_empty  output  1  rlevel <= AE_Thresh

Behaviour:
- Reset (async, rrst_n=0):
  - rbin=0, rptr=0
  - rempty=1, rlevel=0
  - runderflow=0, ralmost_empty=1
  - Outputs change immediately on rrst_n falling, independent of rclk.
  - Reset mid-burst discards all pointer state; the write side must be reset concurrently (system rule, not checked here).
- Read acceptance:
  - rd_ok = rinc & ~rempty
  - rbinnext = rbin + rd_ok, modulo 2**(Addr_Width+1)
  - rgraynext = (rbinnext>>1) ^ rbinnext
  - rbin and rptr register rbinnext/rgraynext on rclk rising.
- raddr = rbin[Addr_Width-1:0] (combinational from the register). Data for the current raddr is valid in the same cycle rinc is asserted.
- Empty:
  - rempty <= (rgraynext == rq2_wptr), one-cycle registered.
  - Reading the last entry asserts rempty the cycle after the read.
  - Empty deassertion lags a write by the sync latency plus one rclk. This is pessimistic, never false-empty.
- Level:
  - wbin = gray2bin(rq2_wptr)
  - rlevel <= wbin - rbinnext, modulo 2**(Addr_Width+1); range 0..2**Addr_Width.
  - rlevel = 0 exactly when rempty = 1.
- Wrap-around: rbin rolls from 2**(Addr_Width+1)-1 to 0; Gray rolls correspondingly with a single-bit change. Level arithmetic must remain correct across the wrap.
- Underflow:
  - rinc & rempty sets runderflow next cycle; pointers do not move.
  - rclr_uf clears it next cycle.
  - If set and clear occur in the same cycle, set wins.
- rq2_wptr changes only by single Gray steps per write clock. Multiple steps between rclk edges are legal, since the value is always a valid Gray code.

Optional Feature:
- Macro: ASYNC_FIFO_ALMOST_EMPTY_EN.
- Defined: ralmost_empty <= (wbin - rbinnext) <= AE_Thresh, registered, reset 1.
- Undefined: ralmost_empty tied to 0 (port retained, no logic); AE_Thresh unused.

Decomposition:
- Shared package async_fifo_pkg holds:
  - bin2gray and gray2bin functions
  - pointer-width helper constant (Addr_Width+1)
  - depth constant
- These are shared with the write-side full generator.
- One sub-module is natural: gray2bin_conv (parameterised width, combinational XOR prefix), instantiated for rq2_wptr.

Test Plan (Addr_Width=4, AE_Thresh=2):
- Reset → rrst_n=0 mid-cycle with rinc=1: rempty=1, rptr=0, raddr=0, rlevel=0, runderflow=0 immediately; held through release.
- Fill and drain:
  - Drive rq2_wptr through Gray of 1..16 with rinc=0 → rlevel tracks 1..16, rempty=0 one cycle after first step.
  - Then 16 reads → raddr 0..15, rempty=1 the cycle after the 16th read, rlevel=0.
- Wrap → run 40 write/read pairs: rbin passes 31→0, rptr goes Gray 10000→00000, rlevel is never negative, and no spurious rempty occurs while data is present.
- Underflow:
  - rempty=1, rinc=1 for one cycle → runderflow=1, rbin unchanged.
  - rclr_uf=1 with simultaneous rinc=1 → runderflow stays 1.
  - rclr_uf alone → 0.
- Simultaneous → rlevel=1, rinc=1 in the same cycle rq2_wptr advances by 1 → rempty stays 0, rlevel stays 1.
- Almost-empty (macro defined) → levels 3,2,1,0 give ralmost_empty 0,1,1,1. Macro undefined → ralmost_empty always 0.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO (read-side empty and write-side full generators).
package async_fifo_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Zero-extended inputs decode correctly because leading zeros leave the prefix XOR unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
  parameter int Width = 5
) (
  input  logic [Width-1:0] gray,
  output logic [Width-1:0] bin
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    assign bin[i] = ^gray[Width-1:i];
  end

endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer, empty flag, fill level and underflow status for the dual-clock FIFO.
// Optional almost-empty flag is built only when ASYNC_FIFO_ALMOST_EMPTY_EN is defined.
module rptr_empty
  import async_fifo_pkg::*;
#(
  parameter int Addr_Width = 4,
  parameter int AE_Thresh  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [Addr_Width:0]   rq2_wptr,
  input  logic                  rclr_uf,
  output logic [Addr_Width-1:0] raddr,
  output logic [Addr_Width:0]   rptr,
  output logic                  rempty,
  output logic [Addr_Width:0]   rlevel,
  output logic                  runderflow,
  output logic                  ralmost_empty
);

  localparam int PtrW  = ptr_width(Addr_Width);
  localparam int Depth = fifo_depth(Addr_Width);

  if (AE_Thresh < 0 || AE_Thresh > Depth) begin : g_bad_thresh
    $error("rptr_empty: AE_Thresh must lie within 0..2**Addr_Width");
  end

  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] rbinnext;
  logic [PtrW-1:0] rgraynext;
  logic [PtrW-1:0] wbin;
  logic [PtrW-1:0] level_next;
  logic            rd_ok;

  gray2bin_conv #(.Width(PtrW)) u_wptr_dec (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  assign rd_ok      = rinc & ~rempty;
  assign rbinnext   = rbin + PtrW'(rd_ok);
  assign rgraynext  = PtrW'(bin2gray(32'(rbinnext)));
  // Modular subtraction keeps the level right when either pointer wraps past its top value.
  assign level_next = wbin - rbinnext;
  assign raddr      = rbin[Addr_Width-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      rlevel <= '0;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
      rlevel <= level_next;
    end
  end

  // A fresh underflow takes priority over a clear arriving in the same cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc && rempty) begin
      runderflow <= 1'b1;
    end else if (rclr_uf) begin
      runderflow <= 1'b0;
    end
  end

`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ralmost_empty <= 1'b1;
    end else begin
      ralmost_empty <= (level_next <= PtrW'(AE_Thresh));
    end
  end
`else
  assign ralmost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Randomised self-checking bench for rptr_empty against an unbounded read/write count model.
module tb_rptr_empty;
  import async_fifo_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int PW    = AW + 1;
  localparam int DEP   = 1 << AW;
  localparam int AE    = 2;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rinc;
  logic [PW-1:0] rq2_wptr;
  logic          rclr_uf;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic [PW-1:0] rlevel;
  logic          runderflow;
  logic          ralmost_empty;

  int nVectors = 0;
  int nMiscompares = 0;
  int wrCount = 0;
  int rdCount = 0;
  bit mEmpty = 1'b1;
  bit mUnder = 1'b0;

  rptr_empty #(.Addr_Width(AW), .AE_Thresh(AE)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rclr_uf       (rclr_uf),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .rlevel        (rlevel),
    .runderflow    (runderflow),
    .ralmost_empty (ralmost_empty)
  );

  always #5 rclk = ~rclk;

  function automatic logic [PW-1:0] toGray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 * DEP));
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Compare every output against the count-based model.
  task automatic checkAll(input string tag);
    int level;
    bit expAe;
    level = wrCount - rdCount;
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
    expAe = (level <= AE);
`else
    expAe = 1'b0;
`endif
    checkOutput({tag, ".raddr"}, 32'(raddr), 32'(rdCount % DEP));
    checkOutput({tag, ".rptr"}, 32'(rptr), 32'(toGray(rdCount)));
    checkOutput({tag, ".rempty"}, 32'(rempty), 32'(mEmpty));
    checkOutput({tag, ".rlevel"}, 32'(rlevel), 32'(level));
    checkOutput({tag, ".runderflow"}, 32'(runderflow), 32'(mUnder));
    checkOutput({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(expAe));
  endtask

  // One read-clock cycle: wSteps writes become visible, optional read and clear.
  task automatic applyStimulus(input string tag, input int wSteps, input bit inc, input bit clr);
    @(negedge rclk);
    wrCount  += wSteps;
    rq2_wptr  = toGray(wrCount);
    rinc      = inc;
    rclr_uf   = clr;
    if (inc && mEmpty) mUnder = 1'b1;
    else if (clr) mUnder = 1'b0;
    if (inc && !mEmpty) rdCount++;
    mEmpty = (rdCount == wrCount);
    @(posedge rclk);
    #1;
    checkAll(tag);
  endtask

  task automatic resetModel();
    wrCount = 0;
    rdCount = 0;
    mEmpty  = 1'b1;
    mUnder  = 1'b0;
  endtask

  initial begin
    int w;
    int room;
    rrst_n   = 1'b1;
    rinc     = 1'b0;
    rclr_uf  = 1'b0;
    rq2_wptr = '0;
    #2 rrst_n = 1'b0;
    #1 checkAll("reset");
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    $display("[TB] fill and drain");

    for (int i = 0; i < DEP; i++) applyStimulus("fill", 1, 1'b0, 1'b0);
    for (int i = 0; i < DEP; i++) applyStimulus("drain", 0, 1'b1, 1'b0);
    applyStimulus("drained", 0, 1'b0, 1'b0);

    $display("[TB] wrap");
    for (int i = 0; i < 40; i++) applyStimulus("wrap", 1, 1'b1, 1'b0);
    applyStimulus("wrap_drain", 0, 1'b1, 1'b0);

    $display("[TB] underflow");
    applyStimulus("uf_set", 0, 1'b1, 1'b0);
    applyStimulus("uf_set_wins", 0, 1'b1, 1'b1);
    applyStimulus("uf_clear", 0, 1'b0, 1'b1);

    $display("[TB] simultaneous read and write");
    applyStimulus("simul_pre", 1, 1'b0, 1'b0);
    applyStimulus("simul", 1, 1'b1, 1'b0);

    $display("[TB] almost-empty levels");
    applyStimulus("ae_fill", 2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("ae_level", 0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      room = DEP - (wrCount - rdCount);
      w = $urandom_range(0, 2);
      if (w > room) w = room;
      applyStimulus("random", w, ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end
    applyStimulus("pre_reset", 0, 1'b1, 1'b0);

    $display("[TB] mid-cycle reset");
    @(posedge rclk);
    #3;
    rinc     = 1'b1;
    rrst_n   = 1'b0;
    rq2_wptr = '0;
    resetModel();
    #1 checkAll("reset_mid");
    @(posedge rclk);
    #1 checkAll("reset_hold");
    @(negedge rclk);
    rrst_n = 1'b1;
    rinc   = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("post_reset", 1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
